display_scan_ctrl: RTL and testbench



---
 rtl/display_pkg.sv | 23 ++
 rtl/display_scan_ctrl_bcd_seg_dec.sv | 27 ++
 rtl/display_scan_ctrl.sv | 122 ++++++++++++
 tb/tb_display_scan_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared types and constants for the seven-segment scan path.
//   bcd_t          4-bit BCD digit code
//   scan_state_t   per-slot phase: BLANK (anti-ghosting window) / SHOW
//   SEG_*          active-low {g,f,e,d,c,b,a} patterns
package display_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic {BLANK, SHOW} scan_state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/display_scan_ctrl_bcd_seg_dec.sv
// bcd_seg_dec: combinational BCD to active-low seven-segment decoder.
//   bcd  in   4-bit digit code
//   seg  out  active-low {g,f,e,d,c,b,a}; codes above 9 decode to all-off
module bcd_seg_dec
    import display_pkg::*;
(
    input  bcd_t       bcd,
    output logic [6:0] seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed scanner for a common-anode
// NUM_DIGITS-digit seven-segment display with a double-buffered BCD frame.
//   clk, rst_n   clock, asynchronous active-low reset
//   en           scan enable; when low, outputs are dark and load writes active
//   load, value  capture strobe and BCD frame ([3:0] = digit 0)
//   blank_mask   per-digit forced blank, sampled live
//   anodes       active-low digit enables (registered)
//   segments     active-low {g,f,e,d,c,b,a} (registered)
//   digit_idx    slot currently scanned
//   frame_done   one-cycle pulse after the last slot wraps to slot 0
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int LZ_SUPPRESS  = 1,
    localparam int IDX_W       = $clog2(NUM_DIGITS),
    localparam int CNT_W       = $clog2(SLOT_CYCLES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic [6:0]              segments,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_done
);

    logic [CNT_W-1:0]                cnt;
    logic [NUM_DIGITS-1:0][3:0]      active;
    logic [NUM_DIGITS-1:0][3:0]      pending;
    logic                            pend_valid;
    logic [NUM_DIGITS-1:0]           lz_mask;
    logic [6:0]                      dec_seg;
    logic                            slot_end;
    logic                            wrap;
    logic                            digit_blank;
    scan_state_t                     phase;

    assign slot_end    = (cnt == CNT_W'(SLOT_CYCLES - 1));
    assign wrap        = slot_end && (digit_idx == IDX_W'(NUM_DIGITS - 1));
    assign phase       = (cnt < CNT_W'(BLANK_CYCLES)) ? BLANK : SHOW;
    assign digit_blank = blank_mask[digit_idx] | lz_mask[digit_idx];

    // Leading-zero run from the MSB down; digit 0 always stays visible.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run   = zero_run & (active[i] == 4'd0);
            lz_mask[i] = (LZ_SUPPRESS != 0) && zero_run && (i != 0);
        end
    end

    bcd_seg_dec u_dec (
        .bcd (active[digit_idx]),
        .seg (dec_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            digit_idx  <= '0;
            anodes     <= '1;
            segments   <= SEG_BLANK;
            frame_done <= 1'b0;
            active     <= '0;
            pending    <= '0;
            pend_valid <= 1'b0;
        end else begin
            // Frame buffers: active only changes at a frame boundary while
            // scanning, so a displayed frame is never torn.
            if (!en) begin
                if (load) begin
                    active     <= value;
                    pend_valid <= 1'b0;
                end
            end else if (wrap) begin
                if (load)            active <= value;
                else if (pend_valid) active <= pending;
                pend_valid <= 1'b0;
            end else if (load) begin
                pending    <= value;
                pend_valid <= 1'b1;
            end

            if (!en) begin
                cnt        <= '0;
                digit_idx  <= '0;
                anodes     <= '1;
                segments   <= SEG_BLANK;
                frame_done <= 1'b0;
            end else begin
                cnt        <= slot_end ? '0 : cnt + CNT_W'(1);
                frame_done <= wrap;
                if (slot_end)
                    digit_idx <= wrap ? '0 : digit_idx + IDX_W'(1);
                // Outputs reflect the pre-edge cnt/digit_idx (one cycle late).
                case (phase)
                    BLANK: begin
                        anodes   <= '1;
                        segments <= SEG_BLANK;
                    end
                    SHOW: begin
                        anodes   <= ~(NUM_DIGITS'(1) << digit_idx);
                        segments <= digit_blank ? SEG_BLANK : dec_seg;
                    end
                    default: begin
                        anodes   <= '1;
                        segments <= SEG_BLANK;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: randomized + directed bench for display_scan_ctrl.
// Two instances share inputs: dut0 without and dut1 with leading-zero blanking.
// The reference tracks a free-running scan time t since scan start; slot and
// in-slot position are t/SLOT and t%SLOT.
module tb_display_scan_ctrl;

    localparam int N    = 4;
    localparam int SLOT = 8;
    localparam int BLK  = 2;
    localparam logic [6:0] SEG_TAB [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  blank_mask = '0;
    logic [3:0]  an0, an1;
    logic [6:0]  sg0, sg1;
    logic [1:0]  ix0, ix1;
    logic        fd0, fd1;

    always #5 clk = ~clk;

    display_scan_ctrl #(.NUM_DIGITS(N), .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLK),
                        .LZ_SUPPRESS(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value(value),
        .blank_mask(blank_mask), .anodes(an0), .segments(sg0),
        .digit_idx(ix0), .frame_done(fd0));

    display_scan_ctrl #(.NUM_DIGITS(N), .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLK),
                        .LZ_SUPPRESS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value(value),
        .blank_mask(blank_mask), .anodes(an1), .segments(sg1),
        .digit_idx(ix1), .frame_done(fd1));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          t = 0;
    int          act = 0;
    int          pend = 0;
    bit          pv = 0;
    logic [3:0]  e_an = 4'hF;
    logic [6:0]  e_sg0 = 7'h7F;
    logic [6:0]  e_sg1 = 7'h7F;
    logic [1:0]  e_ix = '0;
    logic        e_fd = 1'b0;

    function automatic logic [6:0] digit_seg(input int word, input int slot,
                                             input logic [3:0] mask, input bit lz);
        int d;
        d = (word >> (4 * slot)) & 15;
        if (mask[slot]) return 7'h7F;
        if (lz && slot != 0 && (word >> (4 * slot)) == 0) return 7'h7F;
        if (d > 9) return 7'h7F;
        return SEG_TAB[d];
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                t = 0; act = 0; pend = 0; pv = 0;
                e_an = 4'hF; e_sg0 = 7'h7F; e_sg1 = 7'h7F; e_ix = '0; e_fd = 1'b0;
            end else if (!en) begin
                t = 0;
                e_an = 4'hF; e_sg0 = 7'h7F; e_sg1 = 7'h7F; e_ix = '0; e_fd = 1'b0;
                if (load) begin act = int'(value); pv = 0; end
            end else begin
                int slot, c;
                slot = (t / SLOT) % N;
                c    = t % SLOT;
                if (c < BLK) begin
                    e_an = 4'hF; e_sg0 = 7'h7F; e_sg1 = 7'h7F;
                end else begin
                    e_an  = 4'hF & ~(4'b0001 << slot);
                    e_sg0 = digit_seg(act, slot, blank_mask, 1'b0);
                    e_sg1 = digit_seg(act, slot, blank_mask, 1'b1);
                end
                e_fd = ((t % (SLOT * N)) == SLOT * N - 1);
                if (e_fd) begin
                    if (load)    act = int'(value);
                    else if (pv) act = pend;
                    pv = 0;
                end else if (load) begin
                    pend = int'(value); pv = 1;
                end
                t++;
                e_ix = 2'((t / SLOT) % N);
            end
        end
    end

    // ---------------- every-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            chk("anodes0",   32'(an0), 32'(e_an));
            chk("segments0", 32'(sg0), 32'(e_sg0));
            chk("digit0",    32'(ix0), 32'(e_ix));
            chk("frame0",    32'(fd0), 32'(e_fd));
            chk("anodes1",   32'(an1), 32'(e_an));
            chk("segments1", 32'(sg1), 32'(e_sg1));
            chk("digit1",    32'(ix1), 32'(e_ix));
            chk("frame1",    32'(fd1), 32'(e_fd));
        end
    end

    // ---------------- stimulus ----------------
    int cur = -1;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance so the outputs visible now belong to scan time k.
    task automatic to_t(input int k);
        tick(k - cur);
        cur = k;
    endtask

    task automatic start_scan(input bit do_load, input logic [15:0] v);
        en = 1'b0; load = do_load; value = v;
        tick(1);
        load = 1'b0; en = 1'b1; cur = -1;
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        for (int i = 0; i < 4; i++)
            v[4*i +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                      : 4'($urandom_range(0, 9));
        if ($urandom_range(0, 2) == 0)
            v = v & (16'hFFFF >> (4 * $urandom_range(1, 4)));
        return v;
    endfunction

    initial begin
        tick(3);
        chk("reset_anodes", 32'(an0), 32'hF);
        chk("reset_segments", 32'(sg0), 32'h7F);

        // 1: load 4321 right out of reset; first frame still shows zeros
        rst_n = 1'b1; en = 1'b1; load = 1'b1; value = 16'h4321; cur = -1;
        to_t(0); load = 1'b0;
        to_t(4);  chk("t1_old_zero", 32'(sg0), 32'b1000000);
        to_t(12); chk("t1_lz_zero",  32'(sg1), 32'h7F);
        to_t(31); chk("t1_fd_first", 32'(fd0), 32'h1);
        to_t(35); chk("t1_s0_an", 32'(an0), 32'b1110);
                  chk("t1_s0_sg", 32'(sg0), 32'b1111001);
        to_t(60); chk("t1_s3_an", 32'(an0), 32'b0111);
                  chk("t1_s3_sg", 32'(sg0), 32'b0011001);
        to_t(63); chk("t1_fd", 32'(fd0), 32'h1);
        to_t(64); chk("t1_fd_low", 32'(fd0), 32'h0);

        // 2: second load before the wrap overwrites the pending frame
        start_scan(1'b0, 16'h0);
        to_t(5);  load = 1'b1; value = 16'h1234;
        to_t(6);  load = 1'b0;
        to_t(10); load = 1'b1; value = 16'h5678;
        to_t(11); load = 1'b0;
        to_t(35); chk("t2_s0", 32'(sg0), 32'b0000000);
        to_t(59); chk("t2_s3", 32'(sg0), 32'b0010010);

        // 3: leading-zero blanking on dut1
        start_scan(1'b1, 16'h0050);
        to_t(4);  chk("t3_d0", 32'(sg1), 32'b1000000);
        to_t(12); chk("t3_d1", 32'(sg1), 32'b0010010);
        to_t(20); chk("t3_d2_sg", 32'(sg1), 32'h7F);
                  chk("t3_d2_an", 32'(an1), 32'b1011);
        to_t(28); chk("t3_d3_sg", 32'(sg1), 32'h7F);
                  chk("t3_d3_nolz", 32'(sg0), 32'b1000000);
        start_scan(1'b1, 16'h0000);
        to_t(4);  chk("t3_zero_d0", 32'(sg1), 32'b1000000);
        to_t(12); chk("t3_zero_d1", 32'(sg1), 32'h7F);
                  chk("t3_zero_an", 32'(an1), 32'b1101);

        // 4: invalid code and live blank mask
        start_scan(1'b1, 16'h34C2);
        to_t(12); chk("t4_code_c", 32'(sg0), 32'h7F);
                  chk("t4_code_an", 32'(an0), 32'b1101);
        to_t(20); chk("t4_d2", 32'(sg0), 32'b0011001);
        to_t(21); blank_mask = 4'b0100;
        to_t(22); chk("t4_mask_sg", 32'(sg0), 32'h7F);
                  chk("t4_mask_an", 32'(an0), 32'b1011);
        to_t(28); chk("t4_d3", 32'(sg0), 32'b0110000);
        blank_mask = 4'b0000;

        // 5: drop en mid-SHOW, direct load while disabled, restart
        start_scan(1'b0, 16'h0);
        to_t(20); en = 1'b0;
        tick(1);  chk("t5_off_an", 32'(an0), 32'hF);
        load = 1'b1; value = 16'h9999;
        tick(1);  load = 1'b0; en = 1'b1; cur = -1;
        to_t(0);  chk("t5_blank", 32'(an0), 32'hF);
        to_t(4);  chk("t5_nine", 32'(sg0), 32'b0010000);
                  chk("t5_nine_an", 32'(an0), 32'b1110);

        // 6: asynchronous reset mid-slot
        start_scan(1'b0, 16'h0);
        to_t(13);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_an", 32'(an0), 32'hF);
        chk("t6_sg", 32'(sg0), 32'h7F);
        chk("t6_ix", 32'(ix0), 32'h0);
        tick(1); rst_n = 1'b1;
        tick(40);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            load  = ($urandom_range(0, 9) == 0);
            value = rand_bcd();
            if ($urandom_range(0, 49) == 0) blank_mask = 4'($urandom);
            if (en) begin
                if ($urandom_range(0, 399) == 0) en = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                en = 1'b1;
            end
            tick(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
